jtframe_rom_arb: RTL and testbench
==================================

JTFRAME_ROM_ARB -- requirements
Module: jtframe_rom_arb

Interface
REQ-001 SHALL have parameter CH, default 2, meaning number of ROM client channels (legal 1..8).
REQ-002 SHALL have parameter AW, default 22, meaning SDRAM word-address width.
REQ-003 SHALL have parameter OFFSET, default all-zero, CH*AW bits, meaning per-channel base; channel i occupies bits [i*AW +: AW].
REQ-004 SHALL have parameter RR, default 0, meaning arbitration mode: 0 = fixed priority with highest index winning, 1 = round-robin.
REQ-005 SHALL have parameter TMO, default 63, meaning the retry timeout in clk cycles while waiting for data; 0 disables retry.
REQ-006 SHALL have parameter RDY_W, default 4, meaning the width of the post-reset ready delay counter.
REQ-007 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-009 SHALL have port downloading, input, 1, meaning ROM download in progress; acts as a synchronous clear.
REQ-010 SHALL have port loop_rst, input, 1, meaning SDRAM controller loop reset; acts as a synchronous clear.
REQ-011 SHALL have port ch_req, input, CH, meaning per-channel request levels.
REQ-012 SHALL have port ch_addr, input, CH*AW, meaning per-channel word addresses, packed like OFFSET.
REQ-013 SHALL have port ch_sel, output, CH, meaning one-hot owner of the transfer in course; it is the client's data write enable.
REQ-014 SHALL have port sdram_req, output, 1, meaning request to the SDRAM controller.
REQ-015 SHALL have port sdram_ack, input, 1, meaning the controller accepted the request.
REQ-016 SHALL have port data_rdy, input, 1, meaning read data is valid this cycle.
REQ-017 SHALL have port sdram_addr, output, AW, meaning the issued word address.
REQ-018 SHALL have port ready, output, 1, meaning the arbiter is out of reset and clear.
REQ-019 SHALL have port busy, output, 1, meaning a transfer is outstanding (ch_sel != 0).

Function
REQ-020 SHALL implement the FSM states IDLE, WAIT_ACK and WAIT_DATA.
REQ-021 SHALL form eligible = ch_req & ~ch_sel, so the channel being served is never re-granted in its own completion cycle.
REQ-022 SHALL, in IDLE with eligible != 0, grant the winner and set ch_sel one-hot, sdram_req=1 and sdram_addr = OFFSET[i] + ch_addr[i] mod 2^AW, then go to WAIT_ACK; all of these are registered, for a 1-cycle latency.
REQ-023 SHALL, in WAIT_ACK on sdram_ack, clear sdram_req and go to WAIT_DATA.
REQ-024 SHALL, in WAIT_DATA or WAIT_ACK on data_rdy, end the transfer and in the same cycle either grant the next eligible channel (back-to-back, same registered outputs as REQ-022) or clear ch_sel and return to IDLE.
REQ-025 SHALL treat sdram_ack and data_rdy in the same cycle as completion, following REQ-024.
REQ-026 SHALL, with RR=1, search eligible channels starting from (last granted + 1) mod CH; last granted resets to CH-1.
REQ-027 SHALL keep sdram_addr and ch_sel stable from grant until completion.
REQ-028 SHALL, with TMO!=0, count cycles in WAIT_DATA and, when the count reaches TMO without data_rdy, reassert sdram_req with the same address and owner, go to WAIT_ACK and zero the count.
REQ-029 SHALL shift ready through an RDY_W-bit counter after a clear, so ready rises RDY_W+1 cycles after the last clear cycle.
REQ-030 SHALL, while downloading or loop_rst is high, hold state IDLE, ch_sel=0, sdram_req=0, sdram_addr=0, the retry count at 0, ready=0 and the ready counter at 0, overriding all other events, including mid-transfer.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force the REQ-030 values and the round-robin pointer to CH-1.
REQ-032 SHALL produce no request in the first cycle after rst_n deasserts.

Structure
REQ-033 SHALL define the FSM state encoding in the shared jtframe package.
REQ-034 SHALL place the priority/round-robin winner search in one combinational sub-module, jtframe_arb_pick, parametrised by CH and RR.
REQ-035 SHALL keep the address adder and the FSM in the top module.

Verification
REQ-036 SHALL cover: CH=2, RR=0, ch_req=2'b11 -> ch_sel=2'b10 first with sdram_addr=OFFSET[1]+ch_addr[1], then 2'b01 back-to-back on data_rdy.
REQ-037 SHALL cover: CH=4, RR=1, all requests held high -> grant order 0,1,2,3,0.
REQ-038 SHALL cover: OFFSET=22'h3FFFF0, ch_addr=22'h20 -> sdram_addr=22'h000010 (wrap-around).
REQ-039 SHALL cover: TMO=8, sdram_ack given but data_rdy withheld -> sdram_req reasserted 8 cycles later with an unchanged address.
REQ-040 SHALL cover: loop_rst pulsed in WAIT_DATA -> next cycle ch_sel=0, sdram_req=0, ready=0; ready high RDY_W+1 cycles after loop_rst falls.
REQ-041 SHALL cover: sdram_ack and data_rdy in the same cycle -> the transfer completes and no retry occurs.

Source files
------------

// File: rtl/jtframe_pkg.sv
// jtframe_pkg
// Shared definitions for the jtframe ROM arbiter slice.
//   arb_state_e : arbiter FSM encoding (IDLE / WAIT_ACK / WAIT_DATA)
//   clog2_min1  : index width helper that never returns zero, so a
//                 single-channel or timeout-disabled build still gets
//                 a legal 1-bit vector.
package jtframe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// jtframe_arb_pick
// Combinational winner search among eligible ROM channels.
// Ports:
//   eligible   [CH-1:0] : channels allowed to win this cycle
//   last_idx   [IW-1:0] : most recently granted channel (round-robin only)
//   found               : at least one channel is eligible
//   win_idx    [IW-1:0] : index of the winning channel
//   win_onehot [CH-1:0] : one-hot form of win_idx, zero when nothing found
// RR=0 picks the highest eligible index; RR=1 scans upward starting at
// (last_idx + 1) mod CH, wrapping around.
module jtframe_arb_pick
  import jtframe_pkg::*;
#(
  parameter int CH = 2,
  parameter int RR = 0,
  localparam int IW = clog2_min1(CH)
) (
  input  logic [CH-1:0] eligible,
  input  logic [IW-1:0] last_idx,
  output logic          found,
  output logic [IW-1:0] win_idx,
  output logic [CH-1:0] win_onehot
);

  int scan_idx;

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    scan_idx   = 0;
    if (RR != 0) begin
      // First eligible channel found while walking forward from last+1
      for (int k = 0; k < CH; k++) begin
        scan_idx = (int'(last_idx) + 1 + k) % CH;
        if (!found && eligible[scan_idx]) begin
          found   = 1'b1;
          win_idx = IW'(scan_idx);
        end
      end
    end else begin
      // Ascending scan lets the highest eligible index overwrite lower ones
      for (int i = 0; i < CH; i++) begin
        if (eligible[i]) begin
          found   = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
    if (found) begin
      win_onehot[win_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_rom_arb.sv
// jtframe_rom_arb
// Shares one SDRAM read port among CH ROM clients.
// Ports:
//   clk, rst_n         : system clock, asynchronous active-low reset
//   downloading        : ROM download in progress, synchronous clear
//   loop_rst           : SDRAM controller loop reset, synchronous clear
//   ch_req   [CH]      : per-channel request levels
//   ch_addr  [CH*AW]   : per-channel word addresses, channel i at [i*AW +: AW]
//   ch_sel   [CH]      : one-hot owner of the transfer, client write enable
//   sdram_req          : request to the SDRAM controller
//   sdram_ack          : controller accepted the request
//   data_rdy           : read data valid this cycle
//   sdram_addr [AW]    : issued word address (OFFSET[i] + ch_addr[i])
//   ready              : arbiter out of reset/clear
//   busy               : a transfer is outstanding
// All outputs are registered; a grant appears one cycle after the request.
module jtframe_rom_arb
  import jtframe_pkg::*;
#(
  parameter int                  CH     = 2,
  parameter int                  AW     = 22,
  parameter logic [CH*AW-1:0]    OFFSET = '0,
  parameter int                  RR     = 0,
  parameter int                  TMO    = 63,
  parameter int                  RDY_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             downloading,
  input  logic             loop_rst,
  input  logic [CH-1:0]    ch_req,
  input  logic [CH*AW-1:0] ch_addr,
  output logic [CH-1:0]    ch_sel,
  output logic             sdram_req,
  input  logic             sdram_ack,
  input  logic             data_rdy,
  output logic [AW-1:0]    sdram_addr,
  output logic             ready,
  output logic             busy
);

  localparam int IW = clog2_min1(CH);
  localparam int TW = clog2_min1(TMO + 1);
  localparam logic [TW:0] TMO_V = (TW + 1)'(TMO);

  arb_state_e       state_q, state_d;
  logic [CH-1:0]    ch_sel_q, ch_sel_d;
  logic             sdram_req_q, sdram_req_d;
  logic [AW-1:0]    sdram_addr_q, sdram_addr_d;
  logic [IW-1:0]    last_q, last_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [RDY_W-1:0] rdy_cnt_q, rdy_cnt_d;
  logic             ready_q, ready_d;

  logic             clear;
  logic [CH-1:0]    eligible;
  logic             found;
  logic [IW-1:0]    win_idx;
  logic [CH-1:0]    win_onehot;
  logic [AW-1:0]    grant_addr;
  logic             done;
  logic             retry;
  logic             grant;
  logic [TW:0]      tmo_inc;
  logic [RDY_W:0]   rdy_shift;

  assign clear = downloading | loop_rst;

  // The owner is masked out so it cannot win again in its completion cycle
  assign eligible = ch_req & ~ch_sel_q;

  jtframe_arb_pick #(
    .CH (CH),
    .RR (RR)
  ) u_pick (
    .eligible   (eligible),
    .last_idx   (last_q),
    .found      (found),
    .win_idx    (win_idx),
    .win_onehot (win_onehot)
  );

  // Base + offset for the winner; the sum wraps modulo 2^AW
  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < CH; i++) begin
      if (win_onehot[i]) begin
        grant_addr = OFFSET[i*AW +: AW] + ch_addr[i*AW +: AW];
      end
    end
  end

  // Completion, timeout and grant qualifiers shared by both comb processes
  always_comb begin
    tmo_inc = {1'b0, tmo_cnt_q} + {{TW{1'b0}}, 1'b1};
    done    = data_rdy && (state_q != ST_IDLE);
    retry   = (TMO != 0) && (state_q == ST_WAIT_DATA) && !data_rdy &&
              (tmo_inc == TMO_V);
    grant   = found && ((state_q == ST_IDLE) || done);
  end

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ch_sel_q     <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      last_q       <= IW'(CH - 1);
      tmo_cnt_q    <= '0;
      rdy_cnt_q    <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_sel_q     <= ch_sel_d;
      sdram_req_q  <= sdram_req_d;
      sdram_addr_q <= sdram_addr_d;
      last_q       <= last_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rdy_cnt_q    <= rdy_cnt_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state logic; data_rdy wins over sdram_ack in WAIT_ACK
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) state_d = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (data_rdy)       state_d = found ? ST_WAIT_ACK : ST_IDLE;
          else if (sdram_ack) state_d = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (data_rdy)   state_d = found ? ST_WAIT_ACK : ST_IDLE;
          else if (retry) state_d = ST_WAIT_ACK;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output/datapath next values; a clear overrides every other event
  always_comb begin
    ch_sel_d     = ch_sel_q;
    sdram_req_d  = sdram_req_q;
    sdram_addr_d = sdram_addr_q;
    last_d       = last_q;
    tmo_cnt_d    = tmo_cnt_q;
    rdy_shift    = {rdy_cnt_q, 1'b1};
    rdy_cnt_d    = rdy_shift[RDY_W-1:0];
    ready_d      = rdy_cnt_q[RDY_W-1];
    if (clear) begin
      ch_sel_d     = '0;
      sdram_req_d  = 1'b0;
      sdram_addr_d = '0;
      tmo_cnt_d    = '0;
      rdy_cnt_d    = '0;
      ready_d      = 1'b0;
    end else if (grant) begin
      ch_sel_d     = win_onehot;
      sdram_req_d  = 1'b1;
      sdram_addr_d = grant_addr;
      last_d       = win_idx;
      tmo_cnt_d    = '0;
    end else if (done) begin
      ch_sel_d    = '0;
      sdram_req_d = 1'b0;
      tmo_cnt_d   = '0;
    end else if ((state_q == ST_WAIT_ACK) && sdram_ack) begin
      sdram_req_d = 1'b0;
      tmo_cnt_d   = '0;
    end else if (retry) begin
      // Same owner and address, only the request is re-issued
      sdram_req_d = 1'b1;
      tmo_cnt_d   = '0;
    end else if ((state_q == ST_WAIT_DATA) && (TMO != 0)) begin
      tmo_cnt_d = tmo_inc[TW-1:0];
    end
  end

  assign ch_sel     = ch_sel_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign ready      = ready_q;
  assign busy       = |ch_sel_q;

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// tb_jtframe_rom_arb
// Directed bench for jtframe_rom_arb using two instances:
//   dut_a : CH=2, fixed priority, TMO=8, channel 1 base 22'h3FFFF0
//   dut_b : CH=4, round-robin, retry disabled, zero bases
// Inputs change 1 time unit after a rising edge; outputs are sampled at
// the same point after the following edge.
module tb_jtframe_rom_arb;

  localparam int AW = 22;

  logic clk = 1'b0;
  logic rst_n;

  logic          a_downloading, a_loop_rst, a_sdram_ack, a_data_rdy;
  logic [1:0]    a_ch_req;
  logic [2*AW-1:0] a_ch_addr;
  logic [1:0]    a_ch_sel;
  logic          a_sdram_req, a_ready, a_busy;
  logic [AW-1:0] a_sdram_addr;

  logic          b_downloading, b_loop_rst, b_sdram_ack, b_data_rdy;
  logic [3:0]    b_ch_req;
  logic [4*AW-1:0] b_ch_addr;
  logic [3:0]    b_ch_sel;
  logic          b_sdram_req, b_ready, b_busy;
  logic [AW-1:0] b_sdram_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_rom_arb #(
    .CH     (2),
    .AW     (AW),
    .OFFSET ({22'h3FFFF0, 22'h000100}),
    .RR     (0),
    .TMO    (8),
    .RDY_W  (4)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (a_downloading),
    .loop_rst    (a_loop_rst),
    .ch_req      (a_ch_req),
    .ch_addr     (a_ch_addr),
    .ch_sel      (a_ch_sel),
    .sdram_req   (a_sdram_req),
    .sdram_ack   (a_sdram_ack),
    .data_rdy    (a_data_rdy),
    .sdram_addr  (a_sdram_addr),
    .ready       (a_ready),
    .busy        (a_busy)
  );

  jtframe_rom_arb #(
    .CH     (4),
    .AW     (AW),
    .OFFSET ('0),
    .RR     (1),
    .TMO    (0),
    .RDY_W  (4)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (b_downloading),
    .loop_rst    (b_loop_rst),
    .ch_req      (b_ch_req),
    .ch_addr     (b_ch_addr),
    .ch_sel      (b_ch_sel),
    .sdram_req   (b_sdram_req),
    .sdram_ack   (b_sdram_ack),
    .data_rdy    (b_data_rdy),
    .sdram_addr  (b_sdram_addr),
    .ready       (b_ready),
    .busy        (b_busy)
  );

  // Advance one clock and settle just past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset values on both instances, then ready timing after release
  task automatic test_reset();
    rst_n = 1'b0;
    a_downloading = 0; a_loop_rst = 0; a_sdram_ack = 0; a_data_rdy = 0;
    a_ch_req = '0; a_ch_addr = {22'h000020, 22'h000005};
    b_downloading = 0; b_loop_rst = 0; b_sdram_ack = 0; b_data_rdy = 0;
    b_ch_req = '0; b_ch_addr = {22'h000013, 22'h000012, 22'h000011, 22'h000010};
    #23;
    checks++;
    if ({a_ch_sel, a_sdram_req, a_sdram_addr, a_ready, a_busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_a: sel=%b req=%b addr=%h rdy=%b busy=%b, want all zero",
               a_ch_sel, a_sdram_req, a_sdram_addr, a_ready, a_busy);
    end
    checks++;
    if ({b_ch_sel, b_sdram_req, b_sdram_addr, b_ready, b_busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_b: sel=%b req=%b addr=%h rdy=%b busy=%b, want all zero",
               b_ch_sel, b_sdram_req, b_sdram_addr, b_ready, b_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready_early: ready=%b want 0", a_ready);
    end
    step();
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: a=%b b=%b want 1 1", a_ready, b_ready);
    end
  endtask

  // Fixed priority: channel 1 first (with base wrap), channel 0 back-to-back
  task automatic test_priority();
    a_ch_req = 2'b11;
    step();
    checks++;
    if (a_ch_sel !== 2'b10 || a_sdram_req !== 1'b1 || a_sdram_addr !== 22'h000010) begin
      errors++;
      $display("[TB] FAIL prio_first: sel=%b req=%b addr=%h want 10 1 000010",
               a_ch_sel, a_sdram_req, a_sdram_addr);
    end
    a_sdram_ack = 1'b1;
    step();
    a_sdram_ack = 1'b0;
    checks++;
    if (a_sdram_req !== 1'b0 || a_ch_sel !== 2'b10 || a_sdram_addr !== 22'h000010) begin
      errors++;
      $display("[TB] FAIL prio_ack: req=%b sel=%b addr=%h want 0 10 000010",
               a_sdram_req, a_ch_sel, a_sdram_addr);
    end
    step();
    a_data_rdy = 1'b1;
    step();
    a_data_rdy = 1'b0;
    checks++;
    if (a_ch_sel !== 2'b01 || a_sdram_req !== 1'b1 || a_sdram_addr !== 22'h000105) begin
      errors++;
      $display("[TB] FAIL prio_b2b: sel=%b req=%b addr=%h want 01 1 000105",
               a_ch_sel, a_sdram_req, a_sdram_addr);
    end
  endtask

  // Ack and data in one cycle finish the transfer with no later retry
  task automatic test_same_cycle();
    a_ch_req    = 2'b00;
    a_sdram_ack = 1'b1;
    a_data_rdy  = 1'b1;
    step();
    a_sdram_ack = 1'b0;
    a_data_rdy  = 1'b0;
    checks++;
    if (a_ch_sel !== 2'b00 || a_sdram_req !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_done: sel=%b req=%b busy=%b want 00 0 0",
               a_ch_sel, a_sdram_req, a_busy);
    end
    repeat (12) step();
    checks++;
    if (a_sdram_req !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_noretry: req=%b busy=%b want 0 0",
               a_sdram_req, a_busy);
    end
  endtask

  // Data withheld after ack: request comes back 8 cycles later, same address
  task automatic test_timeout();
    a_ch_req = 2'b01;
    step();
    a_ch_req = 2'b00;
    a_sdram_ack = 1'b1;
    step();
    a_sdram_ack = 1'b0;
    checks++;
    if (a_sdram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_acked: req=%b want 0", a_sdram_req);
    end
    repeat (7) step();
    checks++;
    if (a_sdram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_early: req=%b want 0 after 7 cycles", a_sdram_req);
    end
    step();
    checks++;
    if (a_sdram_req !== 1'b1 || a_sdram_addr !== 22'h000105 || a_ch_sel !== 2'b01) begin
      errors++;
      $display("[TB] FAIL tmo_retry: req=%b addr=%h sel=%b want 1 000105 01",
               a_sdram_req, a_sdram_addr, a_ch_sel);
    end
    a_data_rdy = 1'b1;
    step();
    a_data_rdy = 1'b0;
    checks++;
    if (a_ch_sel !== 2'b00 || a_sdram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL tmo_done: sel=%b req=%b want 00 0", a_ch_sel, a_sdram_req);
    end
  endtask

  // loop_rst in WAIT_DATA clears everything; ready returns RDY_W+1 later
  task automatic test_loop_rst();
    a_ch_req = 2'b10;
    step();
    a_ch_req = 2'b00;
    a_sdram_ack = 1'b1;
    step();
    a_sdram_ack = 1'b0;
    step();
    a_loop_rst = 1'b1;
    step();
    a_loop_rst = 1'b0;
    checks++;
    if (a_ch_sel !== 2'b00 || a_sdram_req !== 1'b0 || a_ready !== 1'b0 ||
        a_sdram_addr !== 22'h0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loop_rst_clear: sel=%b req=%b rdy=%b addr=%h busy=%b want 00 0 0 0 0",
               a_ch_sel, a_sdram_req, a_ready, a_sdram_addr, a_busy);
    end
    repeat (4) step();
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loop_rst_ready_early: ready=%b want 0", a_ready);
    end
    step();
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL loop_rst_ready: ready=%b want 1", a_ready);
    end
  endtask

  // Round-robin with every request held: grants 0,1,2,3,0
  task automatic test_round_robin();
    logic [3:0]    exp_sel;
    logic [AW-1:0] exp_addr;
    b_ch_req = 4'b1111;
    step();
    checks++;
    if (b_ch_sel !== 4'b0001 || b_sdram_req !== 1'b1 || b_sdram_addr !== 22'h000010) begin
      errors++;
      $display("[TB] FAIL rr_first: sel=%b req=%b addr=%h want 0001 1 000010",
               b_ch_sel, b_sdram_req, b_sdram_addr);
    end
    b_data_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_sel  = 4'b0001 << (k % 4);
      exp_addr = 22'h000010 + AW'(k % 4);
      checks++;
      if (b_ch_sel !== exp_sel || b_sdram_addr !== exp_addr || b_sdram_req !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: sel=%b addr=%h req=%b want %b %h 1",
                 k, b_ch_sel, b_sdram_addr, b_sdram_req, exp_sel, exp_addr);
      end
    end
    b_ch_req = 4'b0000;
    step();
    b_data_rdy = 1'b0;
    checks++;
    if (b_ch_sel !== 4'b0000 || b_busy !== 1'b0 || b_sdram_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rr_idle: sel=%b busy=%b req=%b want 0000 0 0",
               b_ch_sel, b_busy, b_sdram_req);
    end
  endtask

  // downloading overrides a pending request for as long as it is high
  task automatic test_downloading();
    b_ch_req = 4'b0100;
    step();
    b_downloading = 1'b1;
    repeat (3) step();
    checks++;
    if (b_ch_sel !== 4'b0000 || b_sdram_req !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dl_hold: sel=%b req=%b rdy=%b want 0000 0 0",
               b_ch_sel, b_sdram_req, b_ready);
    end
    b_ch_req = 4'b0000;
    b_downloading = 1'b0;
    repeat (5) step();
    checks++;
    if (b_ready !== 1'b1 || b_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dl_release: ready=%b busy=%b want 1 0", b_ready, b_busy);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_same_cycle();
    test_timeout();
    test_loop_rst();
    test_round_robin();
    test_downloading();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
